i2c_reg_init_seq: RTL and testbench

Table-driven register-initialisation sequencer that sits directly upstream of the two-byte-pointer I2C write engine in the MIPI camera-bridge path. It walks a synchronous table of {16-bit register pointer, 16-bit data} entries and, for each entry, presents POINTER/WDATA and runs the engine's GO/END_OK handshake. It also checks the engine's ACK_OK, retries NACKed writes, supports in-table delay and end markers, and reports DONE/ERROR to the power-up controller.

---
 rtl/i2c_reg_init_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_i2c_reg_init_seq.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_init_seq.sv
// Table-driven I2C register-initialisation sequencer: walks {pointer, data} entries,
// runs the write engine's GO/END_OK handshake per write, retries NACKs, reports DONE/ERROR.
module i2c_reg_init_seq #(
  parameter int TBL_AW    = 8,
  parameter int GO_HOLD   = 4,
  parameter int GAP       = 8,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 4000
) (
  input  logic              PT_CK,
  input  logic              RESET_N,
  input  logic              START,
  output logic [TBL_AW-1:0] TBL_ADDR,
  input  logic [31:0]       TBL_DATA,
  output logic              GO,
  output logic [15:0]       POINTER,
  output logic [15:0]       WDATA,
  input  logic              END_OK,
  input  logic              ACK_OK,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR,
  output logic [TBL_AW-1:0] ERR_ADDR,
  output logic [3:0]        DBG_STATE
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] C_GO_LAST   = CW'(GO_HOLD - 1);
  localparam logic [CW-1:0] C_GAP_LAST  = CW'((GAP < 1) ? 0 : GAP - 1);
  localparam logic [CW-1:0] C_TO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [RW-1:0] C_MAX_RETRY = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_GO_HI     = 4'd3,
    ST_WAIT_BUSY = 4'd4,
    ST_WAIT_DONE = 4'd5,
    ST_CHECK     = 4'd6,
    ST_GAP_W     = 4'd7,
    ST_DELAY     = 4'd8,
    ST_FINISH    = 4'd9,
    ST_FAIL      = 4'd10
  } state_t;

  state_t            r_state;
  logic [TBL_AW-1:0] r_tbl_addr;
  logic [TBL_AW-1:0] r_err_addr;
  logic [15:0]       r_pointer;
  logic [15:0]       r_wdata;
  logic [CW-1:0]     r_cnt;
  logic [RW-1:0]     r_retry;
  logic              r_retry_pend;
  logic              r_ack_last;
  logic              r_go;
  logic              r_busy;
  logic              r_done;
  logic              r_error;

  logic [15:0] w_ptr;
  logic [15:0] w_data;
  logic        w_last_addr;

  assign w_ptr       = TBL_DATA[31:16];
  assign w_data      = TBL_DATA[15:0];
  assign w_last_addr = (r_tbl_addr == {TBL_AW{1'b1}});

  assign TBL_ADDR  = r_tbl_addr;
  assign GO        = r_go;
  assign POINTER   = r_pointer;
  assign WDATA     = r_wdata;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign ERROR     = r_error;
  assign ERR_ADDR  = r_err_addr;
  assign DBG_STATE = r_state;

  // Handshake: GO is a level held GO_HOLD cycles; the engine then drops END_OK while
  // transferring and raises it when idle again, clearing ACK_OK in that same cycle,
  // so the ACK_OK seen in the last END_OK=0 cycle is the final-byte ACK.
  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= ST_IDLE;
      r_tbl_addr   <= '0;
      r_err_addr   <= '0;
      r_pointer    <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_retry_pend <= 1'b0;
      r_ack_last   <= 1'b0;
      r_go         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            r_error    <= 1'b0;
            r_done     <= 1'b0;
            r_tbl_addr <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_FETCH;
          end
        end

        ST_FETCH: r_state <= ST_DECODE;

        ST_DECODE: begin
          if (w_ptr == 16'hFFFE) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FINISH;
          end else if (w_ptr == 16'hFFFF) begin
            r_cnt   <= CW'(w_data);
            r_state <= ST_DELAY;
          end else begin
            r_pointer    <= w_ptr;
            r_wdata      <= w_data;
            r_retry      <= '0;
            r_retry_pend <= 1'b0;
            r_cnt        <= '0;
            r_go         <= 1'b1;
            r_state      <= ST_GO_HI;
          end
        end

        ST_GO_HI: begin
          if (r_cnt == C_GO_LAST) begin
            r_go    <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_WAIT_BUSY;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_WAIT_BUSY: begin
          if (!END_OK) begin
            r_ack_last <= ACK_OK;
            r_cnt      <= '0;
            r_state    <= ST_WAIT_DONE;
          end else if (r_cnt == C_TO_LAST) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_error    <= 1'b1;
            r_err_addr <= r_tbl_addr;
            r_state    <= ST_FAIL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_WAIT_DONE: begin
          if (END_OK) begin
            r_state <= ST_CHECK;
          end else begin
            r_ack_last <= ACK_OK;
            if (r_cnt == C_TO_LAST) begin
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_error    <= 1'b1;
              r_err_addr <= r_tbl_addr;
              r_state    <= ST_FAIL;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        ST_CHECK: begin
          r_cnt <= '0;
          if (r_ack_last) begin
            r_retry_pend <= 1'b0;
            r_state      <= ST_GAP_W;
          end else if (r_retry < C_MAX_RETRY) begin
            r_retry      <= r_retry + 1'b1;
            r_retry_pend <= 1'b1;
            r_state      <= ST_GAP_W;
          end else begin
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_error    <= 1'b1;
            r_err_addr <= r_tbl_addr;
            r_state    <= ST_FAIL;
          end
        end

        ST_GAP_W: begin
          if (r_cnt == C_GAP_LAST) begin
            r_cnt <= '0;
            if (r_retry_pend) begin
              r_go    <= 1'b1;
              r_state <= ST_GO_HI;
            end else if (w_last_addr) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_FINISH;
            end else begin
              r_tbl_addr <= r_tbl_addr + 1'b1;
              r_state    <= ST_FETCH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_DELAY: begin
          if (r_cnt == '0) begin
            if (w_last_addr) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_FINISH;
            end else begin
              r_tbl_addr <= r_tbl_addr + 1'b1;
              r_state    <= ST_FETCH;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        // ERROR and ERR_ADDR deliberately survive the return to IDLE.
        ST_FINISH, ST_FAIL: begin
          if (!START) begin
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_init_seq.sv
// Directed bench for i2c_reg_init_seq: behavioural write engine, synchronous table model,
// one task per scenario, plus a TBL_AW=2 instance for the end-of-table case.
module tb_i2c_reg_init_seq;

  localparam int AW      = 8;
  localparam int ENG_LEN = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] tbl_addr;
  logic [31:0]   tbl_data;
  logic          go;
  logic [15:0]   pointer, wdata;
  logic          end_ok, ack_ok;
  logic          busy, done, error;
  logic [AW-1:0] err_addr;
  logic [3:0]    dbg_state;

  logic          start2 = 1'b0;
  logic [1:0]    tbl_addr2;
  logic [31:0]   tbl_data2;
  logic          go2;
  logic [15:0]   pointer2, wdata2;
  logic          end_ok2 = 1'b1;
  logic          ack_ok2 = 1'b0;
  logic          busy2, done2, error2;
  logic [1:0]    err_addr2;
  logic [3:0]    dbg_state2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cyc;

  logic [31:0] tbl  [0:255];
  logic [31:0] tbl2 [0:3];

  int      nack_left [0:255];
  bit      eng_stuck;
  bit      eng_prev_go;
  int      eng_left;
  logic    eng_ack;
  int      hi_cnt;
  bit      go2_seen;
  logic [15:0]   go_ptr_q[$];
  logic [15:0]   go_wd_q[$];
  logic [AW-1:0] go_addr_q[$];
  int            go_w_q[$];
  int            go_rise_q[$];

  i2c_reg_init_seq #(.TBL_AW(AW), .GO_HOLD(4), .GAP(8), .MAX_RETRY(3), .TIMEOUT(4000)) dut (
    .PT_CK(clk), .RESET_N(rst_n), .START(start), .TBL_ADDR(tbl_addr), .TBL_DATA(tbl_data),
    .GO(go), .POINTER(pointer), .WDATA(wdata), .END_OK(end_ok), .ACK_OK(ack_ok),
    .BUSY(busy), .DONE(done), .ERROR(error), .ERR_ADDR(err_addr), .DBG_STATE(dbg_state)
  );

  i2c_reg_init_seq #(.TBL_AW(2), .GO_HOLD(4), .GAP(8), .MAX_RETRY(3), .TIMEOUT(4000)) dut2 (
    .PT_CK(clk), .RESET_N(rst_n), .START(start2), .TBL_ADDR(tbl_addr2), .TBL_DATA(tbl_data2),
    .GO(go2), .POINTER(pointer2), .WDATA(wdata2), .END_OK(end_ok2), .ACK_OK(ack_ok2),
    .BUSY(busy2), .DONE(done2), .ERROR(error2), .ERR_ADDR(err_addr2), .DBG_STATE(dbg_state2)
  );

  // clock / reset-independent infrastructure
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // table ROM: data for the address seen at one edge is present before the next
  initial forever begin
    @(negedge clk);
    tbl_data  = tbl[tbl_addr];
    tbl_data2 = tbl2[tbl_addr2];
    if (go2) go2_seen = 1'b1;
  end

  // engine model: busy ENG_LEN cycles after GO falls; a NACK shows only on the final busy cycle
  initial begin
    end_ok = 1'b1; ack_ok = 1'b0; eng_prev_go = 1'b0; eng_left = 0; hi_cnt = 0; eng_ack = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        eng_left = 0; eng_prev_go = 1'b0; hi_cnt = 0; end_ok = 1'b1; ack_ok = 1'b0;
      end else begin
        if (go && !eng_prev_go) begin
          go_rise_q.push_back(cyc); go_ptr_q.push_back(pointer);
          go_wd_q.push_back(wdata); go_addr_q.push_back(tbl_addr); hi_cnt = 0;
        end
        if (go) hi_cnt++;
        if (!go && eng_prev_go) begin
          go_w_q.push_back(hi_cnt);
          if (!eng_stuck) begin
            eng_left = ENG_LEN;
            if (nack_left[tbl_addr] > 0) begin
              eng_ack = 1'b0; nack_left[tbl_addr]--;
            end else begin
              eng_ack = 1'b1;
            end
          end
        end
        eng_prev_go = go;
        if (eng_left > 0) begin
          end_ok = 1'b0; ack_ok = (eng_left == 1) ? eng_ack : 1'b1; eng_left--;
        end else begin
          end_ok = 1'b1; ack_ok = 1'b0;
        end
      end
    end
  end

  // driver tasks
  task automatic clear_model();
    go_ptr_q.delete(); go_wd_q.delete(); go_addr_q.delete(); go_w_q.delete(); go_rise_q.delete();
    for (int i = 0; i < 256; i++) begin
      nack_left[i] = 0;
      tbl[i] = 32'hFFFE_0000;
    end
    eng_stuck = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget && timed_out; i++) begin
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0; done_cyc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (go !== 1'b0) begin n_fail++; $display("FAIL rst_go: got %b want 0", go); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b want 0", error); end
    n_tests++; if (tbl_addr !== 8'd0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", tbl_addr); end
    n_tests++; if (err_addr !== 8'd0) begin n_fail++; $display("FAIL rst_err_addr: got %h want 0", err_addr); end
    n_tests++; if ({pointer, wdata} !== 32'd0) begin n_fail++; $display("FAIL rst_ptr_wd: got %h want 0", {pointer, wdata}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (dbg_state !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle: state %0d busy %b want 0/0", dbg_state, busy); end
  endtask

  task automatic test_basic();
    bit to;
    clear_model();
    tbl[0] = 32'h1234_ABCD; tbl[1] = 32'h0010_0001; tbl[2] = 32'h5A5A_00FF;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_done(2000, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL basic_timeout: DONE not seen, got 0 want 1"); end
    n_tests++; if (error !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_flags: error %b busy %b want 0/0", error, busy); end
    n_tests++; if (tbl_addr !== 8'd3) begin n_fail++; $display("FAIL basic_addr: got %0d want 3", tbl_addr); end
    n_tests++; if (go_ptr_q.size() != 3) begin n_fail++; $display("FAIL basic_go_count: got %0d want 3", go_ptr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (go_ptr_q[i] !== tbl[i][31:16] || go_wd_q[i] !== tbl[i][15:0] || go_w_q[i] != 4) begin
        n_fail++;
        $display("FAIL basic_go%0d: got %h/%h width %0d want %h/%h width 4", i, go_ptr_q[i], go_wd_q[i], go_w_q[i], tbl[i][31:16], tbl[i][15:0]);
      end
    end
    // rise to rise: 4 GO + 6 engine wait + 1 CHECK + 8 GAP + 2 FETCH/DECODE
    n_tests++; if (go_rise_q[1] - go_rise_q[0] != 21 || go_rise_q[2] - go_rise_q[1] != 21) begin
      n_fail++; $display("FAIL basic_spacing: got %0d,%0d want 21,21", go_rise_q[1] - go_rise_q[0], go_rise_q[2] - go_rise_q[1]); end
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (done !== 1'b0 || dbg_state !== 4'd0) begin n_fail++; $display("FAIL basic_release: done %b state %0d want 0/0", done, dbg_state); end
  endtask

  task automatic test_delay();
    bit to;
    clear_model();
    tbl[0] = 32'h1111_2222; tbl[1] = 32'hFFFF_0010; tbl[2] = 32'h3333_4444;
    @(negedge clk); start = 1'b1;
    wait_done(2000, to);
    n_tests++; if (to || error !== 1'b0) begin n_fail++; $display("FAIL delay_done: timeout %b error %b want 0/0", to, error); end
    n_tests++; if (go_ptr_q.size() != 2 || go_ptr_q[1] !== 16'h3333) begin n_fail++; $display("FAIL delay_gos: count %0d ptr1 %h want 2/3333", go_ptr_q.size(), go_ptr_q[1]); end
    // back-to-back spacing of 21 plus the delay entry's 2 + 16 + 1
    n_tests++; if (go_rise_q[1] - go_rise_q[0] != 40) begin n_fail++; $display("FAIL delay_spacing: got %0d want 40", go_rise_q[1] - go_rise_q[0]); end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_retry();
    bit to;
    logic [AW-1:0] exp_addr [0:4];
    exp_addr[0] = 8'd0; exp_addr[1] = 8'd1; exp_addr[2] = 8'd1; exp_addr[3] = 8'd1; exp_addr[4] = 8'd2;
    clear_model();
    tbl[0] = 32'h0101_1111; tbl[1] = 32'h0202_2222; tbl[2] = 32'h0303_3333;
    nack_left[1] = 2;
    @(negedge clk); start = 1'b1;
    wait_done(3000, to);
    n_tests++; if (to || error !== 1'b0) begin n_fail++; $display("FAIL retry_done: timeout %b error %b want 0/0", to, error); end
    n_tests++; if (go_ptr_q.size() != 5) begin n_fail++; $display("FAIL retry_go_count: got %0d want 5", go_ptr_q.size()); end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (go_addr_q[i] !== exp_addr[i] || go_ptr_q[i] !== tbl[exp_addr[i]][31:16]) begin
        n_fail++; $display("FAIL retry_go%0d: addr %0d ptr %h want %0d/%h", i, go_addr_q[i], go_ptr_q[i], exp_addr[i], tbl[exp_addr[i]][31:16]);
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nack_fail();
    bit to;
    int n2;
    clear_model();
    tbl[0] = 32'h0A0A_0001; tbl[1] = 32'h0B0B_0002; tbl[2] = 32'h0C0C_0003; tbl[3] = 32'h0D0D_0004;
    nack_left[2] = 100;
    @(negedge clk); start = 1'b1;
    wait_done(3000, to);
    n2 = 0;
    foreach (go_addr_q[i]) if (go_addr_q[i] == 8'd2 && go_ptr_q[i] == 16'h0C0C) n2++;
    n_tests++; if (to || error !== 1'b1 || err_addr !== 8'd2) begin n_fail++; $display("FAIL nack_fail: timeout %b error %b err_addr %0d want 0/1/2", to, error, err_addr); end
    n_tests++; if (go_ptr_q.size() != 6 || n2 != 4) begin n_fail++; $display("FAIL nack_go_count: total %0d entry2 %0d want 6/4", go_ptr_q.size(), n2); end
    n_tests++; if (busy !== 1'b0 || tbl_addr !== 8'd2) begin n_fail++; $display("FAIL nack_stop: busy %b addr %0d want 0/2", busy, tbl_addr); end
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (done !== 1'b0 || error !== 1'b1 || err_addr !== 8'd2) begin n_fail++; $display("FAIL nack_persist: done %b error %b err_addr %0d want 0/1/2", done, error, err_addr); end
  endtask

  task automatic test_timeout();
    bit to;
    clear_model();
    tbl[0] = 32'hFFFF_0000; tbl[1] = 32'h7777_8888;
    eng_stuck = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL tmo_error_clear: got %b want 0", error); end
    wait_done(5000, to);
    n_tests++; if (to || error !== 1'b1 || err_addr !== 8'd1) begin n_fail++; $display("FAIL tmo_fail: timeout %b error %b err_addr %0d want 0/1/1", to, error, err_addr); end
    // GO_HOLD cycles of GO, then TIMEOUT cycles in WAIT_BUSY
    n_tests++; if (go_rise_q.size() != 1 || done_cyc - go_rise_q[0] != 4004) begin
      n_fail++; $display("FAIL tmo_latency: gos %0d latency %0d want 1/4004", go_rise_q.size(), done_cyc - go_rise_q[0]); end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_no_wrap();
    int c0;
    bit to;
    tbl2[0] = 32'hFFFF_0001; tbl2[1] = 32'hFFFF_0002; tbl2[2] = 32'hFFFF_0000; tbl2[3] = 32'hFFFF_0003;
    go2_seen = 1'b0;
    @(negedge clk); start2 = 1'b1; c0 = cyc;
    to = 1'b1;
    for (int i = 0; i < 200 && to; i++) begin
      @(negedge clk);
      if (done2) begin to = 1'b0; done_cyc = cyc; end
    end
    n_tests++; if (to || error2 !== 1'b0 || tbl_addr2 !== 2'd3) begin n_fail++; $display("FAIL wrap_done: timeout %b error %b addr %0d want 0/0/3", to, error2, tbl_addr2); end
    // 1 cycle for START, then delays costing 4 + 5 + 3 + 6
    n_tests++; if (done_cyc - c0 != 19) begin n_fail++; $display("FAIL wrap_latency: got %0d want 19", done_cyc - c0); end
    n_tests++; if (go2_seen || {pointer2, wdata2} !== 32'd0 || err_addr2 !== 2'd0 || dbg_state2 !== 4'd9) begin
      n_fail++; $display("FAIL wrap_quiet: go %b ptr_wd %h err_addr %0d state %0d want 0/0/0/9", go2_seen, {pointer2, wdata2}, err_addr2, dbg_state2); end
    start2 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    bit to;
    bit hit;
    clear_model();
    tbl[0] = 32'h1234_ABCD; tbl[1] = 32'h0010_0001; tbl[2] = 32'h5A5A_00FF;
    @(negedge clk); start = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (go && go_addr_q.size() >= 2) hit = 1'b1;
    end
    n_tests++; if (!hit) begin n_fail++; $display("FAIL midrun_go: second GO not seen, got 0 want 1"); end
    #2 rst_n = 1'b0; start = 1'b0;
    #1;
    n_tests++; if (go !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrun_async: go %b busy %b want 0/0", go, busy); end
    n_tests++; if (tbl_addr !== 8'd0 || pointer !== 16'd0) begin n_fail++; $display("FAIL midrun_clear: addr %0d ptr %h want 0/0", tbl_addr, pointer); end
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++; if (dbg_state !== 4'd0 || busy !== 1'b0 || go !== 1'b0) begin n_fail++; $display("FAIL midrun_idle: state %0d busy %b go %b want 0/0/0", dbg_state, busy, go); end
    go_ptr_q.delete(); go_wd_q.delete(); go_addr_q.delete(); go_w_q.delete(); go_rise_q.delete();
    start = 1'b1;
    wait_done(2000, to);
    n_tests++; if (to || error !== 1'b0 || go_ptr_q.size() != 3) begin n_fail++; $display("FAIL midrun_rerun: timeout %b error %b gos %0d want 0/0/3", to, error, go_ptr_q.size()); end
    n_tests++; if (go_addr_q[0] !== 8'd0 || go_ptr_q[0] !== 16'h1234) begin n_fail++; $display("FAIL midrun_first: addr %0d ptr %h want 0/1234", go_addr_q[0], go_ptr_q[0]); end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    clear_model();
    for (int i = 0; i < 4; i++) tbl2[i] = 32'hFFFE_0000;
    test_reset();
    test_basic();
    test_delay();
    test_retry();
    test_nack_fail();
    test_timeout();
    test_no_wrap();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
